// File: rtl/mmio_console_rx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_console_rx
// Purpose  : 8N1 UART receiver feeding a byte FIFO, read through two MMIO regs
// Revision : 1.0 - initial release
// ============================================================================

typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
} memory_io_req;

typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
} memory_io_rsp;

module mmio_console_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0002_FFF0
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req req,
    output memory_io_rsp rsp,
    input  logic         uart_rx,
    output logic         irq
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [31:0]      STAT_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    logic             sync1_q, sync2_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_w, frm_evt_w;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic             irq_q;
    memory_io_rsp     rsp_q, rsp_d;

    logic             hit_w, rd_w, data_rd_w, stat_rd_w;
    logic             empty_w, full_w, pop_w, push_ok_w, ovr_evt_w;
    logic [31:0]      status_w;

    // Receive state machine: mid-bit sampling driven by a down-counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_w    = 1'b0;
        frm_evt_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF_BIT;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    push_w    = sync2_q;
                    frm_evt_w = !sync2_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus decode; a request carrying any write strobe is never answered
    always_comb begin
        hit_w     = req.valid && ((req.addr == BASE_ADDR) || (req.addr == STAT_ADDR));
        rd_w      = hit_w && (req.do_read != 4'd0) && (req.do_write == 4'd0);
        data_rd_w = rd_w && (req.addr == BASE_ADDR);
        stat_rd_w = rd_w && (req.addr == STAT_ADDR);

        empty_w   = (level_q == '0);
        full_w    = (level_q == LVL_FULL);
        pop_w     = data_rd_w && !empty_w;
        push_ok_w = push_w && (!full_w || pop_w);
        ovr_evt_w = push_w && !push_ok_w;

        status_w  = 32'({9'(level_q), full_w, frame_err_q, overrun_q, !empty_w});

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_w) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop_w) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        level_d     = level_q + LVL_W'(push_ok_w) - LVL_W'(pop_w);

        // A new error in the same cycle as the status read survives the clear
        overrun_d   = (overrun_q && !stat_rd_w) || ovr_evt_w;
        frame_err_d = (frame_err_q && !stat_rd_w) || frm_evt_w;

        rsp_d = '0;
        if (rd_w) begin
            rsp_d.valid = 1'b1;
            rsp_d.addr  = req.addr;
            if (data_rd_w) begin
                rsp_d.data = empty_w ? 32'hFFFF_FFFF : {24'h0, mem_q[rd_ptr_q]};
            end else begin
                rsp_d.data = status_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_w) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            rsp_q       <= '0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= (level_d != '0);
            rsp_q       <= rsp_d;
        end
    end

    assign rsp = rsp_q;
    assign irq = irq_q;

endmodule

`default_nettype wire
